// File: rtl/shift_receiver_pkg.sv
// Shared definitions for the serializer link: receiver states, default word
// width and the even-parity helper also used by the transmitter.
package shift_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Even parity over a zero-extended word: 1 when the word has an odd number of ones.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/shift_out_buf.sv
// One-entry output register with valid/ready handshake and sticky overrun.
// A word completing while the held word is still unconsumed is dropped.
module shift_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             q_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             overrun_q, overrun_d;
    logic             ovr_set_s;

    // Next-state for the held word, its valid flag and the overrun flag.
    always_comb begin
        q_d       = q_q;
        q_valid_d = q_valid_q;
        ovr_set_s = 1'b0;
        if (load) begin
            if (q_valid_q && !q_ready) begin
                ovr_set_s = 1'b1;
            end else begin
                q_d       = d;
                q_valid_d = 1'b1;
            end
        end else if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end else begin
            q_valid_d = q_valid_q;
        end
        // Setting takes priority over a simultaneous clear.
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= {WIDTH{1'b0}};
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/shift_receiver.sv
// Framed LSB-first serial-to-parallel receiver with sticky framing/overrun flags.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit and add parity_err.
module shift_receiver
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             si,
    input  logic             sof,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
`ifdef PARITY_CHECK_EN
    output logic             parity_err,
`endif
    input  logic             clr_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             frame_set_s;
    logic             load_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] shifted_s;
`ifdef PARITY_CHECK_EN
    logic             parity_err_q, parity_err_d;
    logic             parity_set_s;
`endif

    assign shifted_s = {si, sh_q[WIDTH-1:1]};

    // Framing FSM, shift register and bit counter next-state.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        load_s      = 1'b0;
        word_s      = shifted_s;
        frame_set_s = 1'b0;
`ifdef PARITY_CHECK_EN
        parity_set_s = 1'b0;
`endif
        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        sh_d    = shifted_s;
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    if (sof) begin
                        // Restart: this bit begins a fresh word.
                        frame_set_s = 1'b1;
                        sh_d        = shifted_s;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sh_d = shifted_s;
`ifdef PARITY_CHECK_EN
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = PARITY;
`else
                        cnt_d   = CNT_W'(0);
                        state_d = IDLE;
                        load_s  = 1'b1;
`endif
                    end else begin
                        sh_d  = shifted_s;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
`ifdef PARITY_CHECK_EN
                    if (sof) begin
                        frame_set_s = 1'b1;
                        sh_d        = shifted_s;
                        cnt_d       = CNT_W'(1);
                        state_d     = SHIFT;
                    end else if ((even_parity(32'(sh_q)) ^ si) == 1'b0) begin
                        word_s  = sh_q;
                        load_s  = 1'b1;
                        cnt_d   = CNT_W'(0);
                        state_d = IDLE;
                    end else begin
                        parity_set_s = 1'b1;
                        cnt_d        = CNT_W'(0);
                        state_d      = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_W'(0);
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d == SHIFT);
        if (frame_set_s) begin
            frame_err_d = 1'b1;
        end else if (clr_err) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
`ifdef PARITY_CHECK_EN
        if (parity_set_s) begin
            parity_err_d = 1'b1;
        end else if (clr_err) begin
            parity_err_d = 1'b0;
        end else begin
            parity_err_d = parity_err_q;
        end
`endif
    end

    // Receiver state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PARITY_CHECK_EN
    // Sticky parity error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign busy      = busy_q;
    assign frame_err = frame_err_q;

    shift_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .d       (word_s),
        .q_ready (q_ready),
        .clr_err (clr_err),
        .q       (q),
        .q_valid (q_valid),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_shift_receiver.sv
// Self-checking bench for shift_receiver: directed cases with literal
// expectations plus randomized traffic checked against a word-level model.
module tb_shift_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         bit_valid = 1'b0;
    logic         si = 1'b0;
    logic         sof = 1'b0;
    logic         q_ready = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] q;
    logic         q_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: bits gathered so far as an integer, plus output/flag view.
    bit         m_in_word = 1'b0;
    int         m_nbits = 0;
    int         m_acc = 0;
    logic [W-1:0] m_q = '0;
    bit         m_qv = 1'b0;
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;

    shift_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .si        (si),
        .sof       (sof),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: collect bits, emit a word after W bits.
    always @(posedge clk or posedge reset) begin : model
        int nb, acc;
        bit inw, done, fe_set, ov_set, qv;
        logic [W-1:0] qq;
        if (reset) begin
            m_in_word <= 1'b0;
            m_nbits   <= 0;
            m_acc     <= 0;
            m_q       <= '0;
            m_qv      <= 1'b0;
            m_fe      <= 1'b0;
            m_ov      <= 1'b0;
        end else begin
            nb = m_nbits; acc = m_acc; inw = m_in_word;
            qq = m_q; qv = m_qv; done = 1'b0; fe_set = 1'b0; ov_set = 1'b0;
            if (bit_valid) begin
                if (sof) begin
                    fe_set = inw;
                    inw = 1'b1;
                    nb = 1;
                    acc = int'(si);
                end else if (inw) begin
                    acc = acc | (int'(si) << nb);
                    nb = nb + 1;
                end
                if (inw && nb == W) begin
                    done = 1'b1;
                    inw = 1'b0;
                end
            end
            if (done) begin
                if (qv && !q_ready) ov_set = 1'b1;
                else begin
                    qq = acc[W-1:0];
                    qv = 1'b1;
                end
            end else if (qv && q_ready) begin
                qv = 1'b0;
            end
            m_in_word <= inw;
            m_nbits   <= nb;
            m_acc     <= acc;
            m_q       <= qq;
            m_qv      <= qv;
            m_fe      <= fe_set | (m_fe & !clr_err);
            m_ov      <= ov_set | (m_ov & !clr_err);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("q", 32'(q), 32'(m_q));
            cmp("q_valid", 32'(q_valid), 32'(m_qv));
            cmp("busy", 32'(busy), 32'(m_in_word));
            cmp("frame_err", 32'(frame_err), 32'(m_fe));
            cmp("overrun", 32'(overrun), 32'(m_ov));
        end
    end

    // Apply one cycle of inputs; returns 2 time units after the edge that consumed them.
    task automatic drive(input bit bv, input bit s, input bit f, input bit rdy, input bit clr);
        bit_valid = bv; si = s; sof = f; q_ready = rdy; clr_err = clr;
        @(posedge clk);
        #2;
        bit_valid = 1'b0; sof = 1'b0; clr_err = 1'b0;
    endtask

    // Send a full W-bit word LSB first with sof on the first bit.
    task automatic send_word(input logic [W-1:0] w, input bit rdy);
        for (int i = 0; i < W; i++) begin
            drive(1'b1, w[i], i == 0, rdy, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] fr;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk_en = 1'b1;
        cmp("reset_q", 32'(q), 32'h0);
        cmp("reset_q_valid", 32'(q_valid), 32'h0);
        cmp("reset_busy", 32'(busy), 32'h0);
        cmp("reset_flags", 32'({frame_err, overrun}), 32'h0);

        // Basic word 1,1,0,1.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cmp("basic_busy_mid", 32'(busy), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cmp("basic_q", 32'(q), 32'hB);
        cmp("basic_q_valid", 32'(q_valid), 32'h1);
        cmp("basic_busy", 32'(busy), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp("basic_q_valid_one_cycle", 32'(q_valid), 32'h0);

        // Back-to-back words.
        send_word(4'hA, 1'b1);
        cmp("b2b_first", 32'(q), 32'hA);
        send_word(4'h5, 1'b1);
        cmp("b2b_second", 32'(q), 32'h5);
        cmp("b2b_overrun", 32'(overrun), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun with consumer stalled.
        send_word(4'hA, 1'b0);
        send_word(4'h5, 1'b0);
        cmp("ovr_q_held", 32'(q), 32'hA);
        cmp("ovr_flag", 32'(overrun), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cmp("ovr_cleared", 32'(overrun), 32'h0);
        cmp("ovr_consumed", 32'(q_valid), 32'h0);

        // Framing error: restart on the third bit, then 0,0,1,1.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cmp("frame_flag", 32'(frame_err), 32'h1);
        cmp("frame_no_word_yet", 32'(q_valid), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cmp("frame_q", 32'(q), 32'hC);
        cmp("frame_q_valid", 32'(q_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cmp("frame_cleared", 32'(frame_err), 32'h0);

        // Async reset mid-word, mid-clock, with a pending word and set flags.
        send_word(4'h9, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        cmp("arst_q", 32'(q), 32'h0);
        cmp("arst_q_valid", 32'(q_valid), 32'h0);
        cmp("arst_busy", 32'(busy), 32'h0);
        cmp("arst_flags", 32'({frame_err, overrun}), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        send_word(4'h6, 1'b1);
        cmp("arst_new_word", 32'(q), 32'h6);
        cmp("arst_new_valid", 32'(q_valid), 32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            fr = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                send_word(fr, $urandom_range(0, 1) == 1);
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 19) == 0);
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
